// File: rtl/spu_mamulred_seq_pkg.sv
// Shared definitions for the SPU mul-reduce sequencer: one-hot state encoding,
// operation mode and the word-index width.
package spu_mamulred_seq_pkg;

    localparam int WORD_W = 6;

    typedef enum logic [5:0] {
        ST_IDLE = 6'b000001,
        ST_RDA  = 6'b000010,
        ST_RDB  = 6'b000100,
        ST_CHK  = 6'b001000,
        ST_SUB  = 6'b010000,
        ST_DONE = 6'b100000
    } mrs_state_e;

    typedef enum logic {
        MODE_ANOTEQB = 1'b0,
        MODE_AEQUB   = 1'b1
    } mrs_mode_e;

endpackage

// File: rtl/spu_mamrs_ctr.sv
// Word-pointer counter for the mul-reduce sequencer: synchronous clear,
// increment and compare against the latched operand length.
module spu_mamrs_ctr
    import spu_mamulred_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              inc,
    input  logic [WORD_W-1:0] len,
    output logic [WORD_W-1:0] ptr,
    output logic              at_len
);

    logic [WORD_W-1:0] ptr_d;
    logic [WORD_W-1:0] ptr_q;

    // Clear wins over increment so an abort never lets the pointer advance.
    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (inc) begin
            ptr_d = ptr_q + {{(WORD_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr    = ptr_q;
    assign at_len = (ptr_q == len);

endmodule

// File: rtl/spu_mamulred_seq.sv
// Mul-reduce sequencer: steps operand reads for A*A or A*B, then an optional
// subtract-N pass, and pulses red_done on completion.
module spu_mamulred_seq
    import spu_mamulred_seq_pkg::*;
(
    input  logic       rclk,
    input  logic       reset,
    input  logic       se,
    input  logic       spu_maexp_start_mulred_aequb,
    input  logic       spu_maexp_start_mulred_anoteqb,
    input  logic       spu_mactl_kill_op,
    input  logic       spu_mactl_stxa_force_abort,
    input  logic [5:0] spu_maaddr_len_m1,
    input  logic       spu_madp_m_ge_n,
    output logic       spu_mamrs_memren,
    output logic       spu_mamrs_rd_a,
    output logic       spu_mamrs_rd_b,
    output logic       spu_mamrs_mul_en,
    output logic       spu_mamrs_sub_wen,
    output logic [5:0] spu_mamrs_word_ptr,
    output logic       spu_mared_red_done,
    output logic       spu_mamrs_busy
);

    mrs_state_e        state_d, state_q;
    mrs_mode_e         mode_d, mode_q;
    logic [WORD_W-1:0] len_d, len_q;
    logic              ctr_clr;
    logic              ctr_inc;
    logic              at_len;
    logic              abort;
    logic              unused_se;

    assign unused_se = se;
    assign abort     = spu_mactl_kill_op | spu_mactl_stxa_force_abort;

    spu_mamrs_ctr u_ctr (
        .clk    (rclk),
        .rst    (reset),
        .clr    (ctr_clr),
        .inc    (ctr_inc),
        .len    (len_q),
        .ptr    (spu_mamrs_word_ptr),
        .at_len (at_len)
    );

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        len_d   = len_q;
        ctr_clr = 1'b0;
        ctr_inc = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
            ctr_clr = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (spu_maexp_start_mulred_aequb || spu_maexp_start_mulred_anoteqb) begin
                        mode_d  = spu_maexp_start_mulred_aequb ? MODE_AEQUB : MODE_ANOTEQB;
                        len_d   = spu_maaddr_len_m1;
                        ctr_clr = 1'b1;
                        state_d = ST_RDA;
                    end
                end
                ST_RDA: begin
                    if (mode_q == MODE_ANOTEQB) begin
                        state_d = ST_RDB;
                    end else if (at_len) begin
                        state_d = ST_CHK;
                    end else begin
                        ctr_inc = 1'b1;
                    end
                end
                ST_RDB: begin
                    if (at_len) begin
                        state_d = ST_CHK;
                    end else begin
                        ctr_inc = 1'b1;
                        state_d = ST_RDA;
                    end
                end
                ST_CHK: begin
                    ctr_clr = 1'b1;
                    state_d = spu_madp_m_ge_n ? ST_SUB : ST_DONE;
                end
                ST_SUB: begin
                    if (at_len) begin
                        state_d = ST_DONE;
                    end else begin
                        ctr_inc = 1'b1;
                    end
                end
                ST_DONE: begin
                    ctr_clr = 1'b1;
                    state_d = ST_IDLE;
                end
                default: begin
                    ctr_clr = 1'b1;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge rclk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_AEQUB;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            len_q   <= len_d;
        end
    end

    // Outputs decode only the state register, so reset drops them at once.
    always_comb begin
        spu_mamrs_memren   = (state_q == ST_RDA) || (state_q == ST_RDB) || (state_q == ST_SUB);
        spu_mamrs_rd_a     = (state_q == ST_RDA);
        spu_mamrs_rd_b     = (state_q == ST_RDB);
        spu_mamrs_mul_en   = (state_q == ST_RDA) || (state_q == ST_RDB);
        spu_mamrs_sub_wen  = (state_q == ST_SUB);
        spu_mared_red_done = (state_q == ST_DONE);
        spu_mamrs_busy     = (state_q != ST_IDLE);
    end

endmodule

// File: tb/tb_spu_mamulred_seq.sv
// Self-checking bench for spu_mamulred_seq: directed scenarios plus random
// operations compared cycle by cycle against an expected-output queue.
module tb_spu_mamulred_seq;

    logic       rclk;
    logic       reset;
    logic       se;
    logic       start_a;
    logic       start_b;
    logic       kill_op;
    logic       stxa_abort;
    logic [5:0] len_m1;
    logic       m_ge_n;
    logic       memren, rd_a, rd_b, mul_en, sub_wen, red_done, busy;
    logic [5:0] word_ptr;

    int tests = 0;
    int fails = 0;

    // Entry: {busy, memren, rd_a, rd_b, mul_en, sub_wen, red_done, ptr_valid, ptr[5:0]}
    logic [13:0] exp_q[$];

    localparam logic [6:0] O_IDLE = 7'b0000000;
    localparam logic [6:0] O_RDA  = 7'b1110100;
    localparam logic [6:0] O_RDB  = 7'b1101100;
    localparam logic [6:0] O_CHK  = 7'b1000000;
    localparam logic [6:0] O_SUB  = 7'b1100010;
    localparam logic [6:0] O_DONE = 7'b1000001;

    spu_mamulred_seq dut (
        .rclk                           (rclk),
        .reset                          (reset),
        .se                             (se),
        .spu_maexp_start_mulred_aequb   (start_a),
        .spu_maexp_start_mulred_anoteqb (start_b),
        .spu_mactl_kill_op              (kill_op),
        .spu_mactl_stxa_force_abort     (stxa_abort),
        .spu_maaddr_len_m1              (len_m1),
        .spu_madp_m_ge_n                (m_ge_n),
        .spu_mamrs_memren               (memren),
        .spu_mamrs_rd_a                 (rd_a),
        .spu_mamrs_rd_b                 (rd_b),
        .spu_mamrs_mul_en               (mul_en),
        .spu_mamrs_sub_wen              (sub_wen),
        .spu_mamrs_word_ptr             (word_ptr),
        .spu_mared_red_done             (red_done),
        .spu_mamrs_busy                 (busy)
    );

    // ---------------- clock ----------------
    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    function automatic logic [6:0] outs();
        return {busy, memren, rd_a, rd_b, mul_en, sub_wen, red_done};
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    function automatic logic [13:0] ent(input logic [6:0] o, input logic v, input logic [5:0] p);
        return {o, v, p};
    endfunction

    // Reference: the operation's cycle-by-cycle trace from the read/check/subtract rules.
    task automatic build_model(input bit aeq, input int len, input bit ge);
        exp_q.delete();
        for (int i = 0; i <= len; i++) begin
            exp_q.push_back(ent(O_RDA, 1'b1, 6'(i)));
            if (!aeq) exp_q.push_back(ent(O_RDB, 1'b1, 6'(i)));
        end
        exp_q.push_back(ent(O_CHK, 1'b0, 6'd0));
        if (ge) begin
            for (int i = 0; i <= len; i++) exp_q.push_back(ent(O_SUB, 1'b1, 6'(i)));
        end
        exp_q.push_back(ent(O_DONE, 1'b0, 6'd0));
    endtask

    // ---------------- driver ----------------
    task automatic run_op(input bit sa, input bit sb, input int len, input bit ge,
                          input int kill_at, input bit kill_src, input int spur_at,
                          input string name);
        int n;
        logic [13:0] e;
        build_model(sa, len, ge);
        n = exp_q.size();
        @(posedge rclk); #1;
        start_a = sa; start_b = sb; len_m1 = 6'(len); m_ge_n = ge;
        @(posedge rclk); #1;
        start_a = 1'b0; start_b = 1'b0;
        for (int c = 1; c <= n; c++) begin
            kill_op    = (c == kill_at) && !kill_src;
            stxa_abort = (c == kill_at) && kill_src;
            if (c == spur_at) begin
                start_a = 1'b1;
                start_b = 1'b1;
            end
            @(negedge rclk);
            e = exp_q.pop_front();
            chk($sformatf("%s c%0d outs", name, c), {1'b0, outs()}, {1'b0, e[13:7]});
            if (e[6]) chk($sformatf("%s c%0d ptr", name, c), {2'b0, word_ptr}, {2'b0, e[5:0]});
            @(posedge rclk); #1;
            kill_op = 1'b0; stxa_abort = 1'b0; start_a = 1'b0; start_b = 1'b0;
            if (c == kill_at) begin
                for (int k = 1; k <= 2; k++) begin
                    @(negedge rclk);
                    chk($sformatf("%s abort+%0d outs", name, k), {1'b0, outs()}, 8'd0);
                    chk($sformatf("%s abort+%0d ptr", name, k), {2'b0, word_ptr}, 8'd0);
                    if (k == 1) begin
                        @(posedge rclk); #1;
                    end
                end
                return;
            end
        end
        @(negedge rclk);
        chk($sformatf("%s idle outs", name), {1'b0, outs()}, {1'b0, O_IDLE});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        se = 1'b0; start_a = 1'b0; start_b = 1'b0; kill_op = 1'b0; stxa_abort = 1'b0;
        len_m1 = 6'd0; m_ge_n = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge rclk);
        chk("reset outs", {1'b0, outs()}, 8'd0);
        chk("reset ptr", {2'b0, word_ptr}, 8'd0);
        reset = 1'b0;
        @(negedge rclk);
        chk("post-reset idle", {1'b0, outs()}, 8'd0);

        run_op(1'b1, 1'b0, 3, 1'b0, 0, 1'b0, 0, "aequb_L3");
        run_op(1'b0, 1'b1, 3, 1'b1, 0, 1'b0, 0, "anoteqb_L3_sub");
        run_op(1'b0, 1'b1, 0, 1'b0, 0, 1'b0, 0, "anoteqb_L0");
        run_op(1'b1, 1'b0, 0, 1'b1, 0, 1'b0, 0, "aequb_L0_sub");
        run_op(1'b0, 1'b1, 5, 1'b0, 3, 1'b0, 0, "kill_L5");
        run_op(1'b1, 1'b0, 2, 1'b0, 0, 1'b0, 0, "after_kill");
        run_op(1'b1, 1'b1, 1, 1'b0, 0, 1'b0, 0, "both_starts_L1");
        run_op(1'b0, 1'b1, 2, 1'b1, 0, 1'b0, 9, "start_in_sub");
        run_op(1'b1, 1'b0, 4, 1'b0, 7, 1'b1, 0, "stxa_in_done");
        run_op(1'b1, 1'b0, 63, 1'b0, 0, 1'b0, 0, "aequb_L63");

        // Asynchronous reset in the middle of RDB, away from any clock edge.
        @(posedge rclk); #1;
        start_b = 1'b1; len_m1 = 6'd3; m_ge_n = 1'b0;
        @(posedge rclk); #1;
        start_b = 1'b0;
        @(posedge rclk);
        @(negedge rclk);
        chk("pre-reset rdb", {1'b0, outs()}, {1'b0, O_RDB});
        #2 reset = 1'b1;
        #1 chk("async reset outs", {1'b0, outs()}, 8'd0);
        chk("async reset ptr", {2'b0, word_ptr}, 8'd0);
        @(negedge rclk);
        reset = 1'b0;
        @(negedge rclk);
        chk("after reset idle", {1'b0, outs()}, 8'd0);
        chk("after reset ptr", {2'b0, word_ptr}, 8'd0);

        for (int r = 0; r < 20; r++) begin
            int len;
            bit sa, sb, ge, src;
            int kill_at, spur_at;
            len = $urandom_range(0, 7);
            sa = $urandom_range(0, 1);
            sb = sa ? bit'($urandom_range(0, 1)) : 1'b1;
            ge = $urandom_range(0, 1);
            src = $urandom_range(0, 1);
            kill_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2 * len + 6) : 0;
            spur_at = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 2 * len + 6) : 0;
            run_op(sa, sb, len, ge, kill_at, src, spur_at, $sformatf("rand%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spu_mamulred_seq.md
SPU_MAMULRED_SEQ -- requirements
Module: spu_mamulred_seq

Interface
REQ-001 SHALL have port rclk, input, 1, the only clock; every flop is rising-edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port se, input, 1, scan enable; it has no functional effect.
REQ-004 SHALL have port spu_maexp_start_mulred_aequb, input, 1, single-cycle start of a squaring (A==B) mul-reduce.
REQ-005 SHALL have port spu_maexp_start_mulred_anoteqb, input, 1, single-cycle start of a general (A!=B) mul-reduce.
REQ-006 SHALL have port spu_mactl_kill_op, input, 1, abort the current operation.
REQ-007 SHALL have port spu_mactl_stxa_force_abort, input, 1, abort the current operation.
REQ-008 SHALL have port spu_maaddr_len_m1, input, 6, operand length in 64-bit words minus 1 (L).
REQ-009 SHALL have port spu_madp_m_ge_n, input, 1, datapath result >= modulus; valid only in CHK.
REQ-010 SHALL have port spu_mamrs_memren, output, 1, operand memory read enable.
REQ-011 SHALL have port spu_mamrs_rd_a / spu_mamrs_rd_b, output, 1 each, operand select for the current read.
REQ-012 SHALL have port spu_mamrs_mul_en, output, 1, multiply-accumulate step enable.
REQ-013 SHALL have port spu_mamrs_sub_wen, output, 1, subtract-N writeback enable.
REQ-014 SHALL have port spu_mamrs_word_ptr, output, 6, current word index.
REQ-015 SHALL have port spu_mared_red_done, output, 1, single-cycle completion pulse.
REQ-016 SHALL have port spu_mamrs_busy, output, 1, high in every state except IDLE.

Function
REQ-017 SHALL implement states IDLE, RDA, RDB, CHK, SUB and DONE.
REQ-018 In IDLE, a start pulse SHALL latch the mode and L, clear word_ptr to 0 and go to RDA; the cycle after the start pulse is cycle 1.
REQ-019 If both starts are asserted in the same cycle, aequb SHALL take priority.
REQ-020 Start pulses arriving outside IDLE SHALL be ignored.
REQ-021 In RDA: memren=1, rd_a=1, mul_en=1.
  - anoteqb mode: next state RDB.
  - aequb mode: if word_ptr==L, next state CHK; otherwise word_ptr increments and the state stays RDA.
REQ-022 In RDB: memren=1, rd_b=1, mul_en=1. If word_ptr==L, next state CHK; otherwise word_ptr increments and next state RDA.
REQ-023 In CHK: word_ptr clears to 0.
  - spu_madp_m_ge_n=1: next state SUB.
  - otherwise: next state DONE.
REQ-024 In SUB: memren=1, sub_wen=1. If word_ptr==L, next state DONE; otherwise word_ptr increments.
REQ-025 In DONE: spu_mared_red_done=1 for exactly one cycle, then IDLE.
REQ-026 Latency SHALL be:
  - aequb: red_done in cycle L+3.
  - anoteqb: red_done in cycle 2L+4.
  - If SUB is taken: L+1 additional cycles.
REQ-027 word_ptr SHALL never exceed L; no wrap-around is allowed. L=0 SHALL be legal (single word).
REQ-028 kill_op or stxa_force_abort asserted in any state SHALL force IDLE on the next edge.
  - No red_done is produced for the aborted operation.
  - word_ptr clears to 0.
  - Abort has priority over every transition, including DONE.
REQ-029 All outputs SHALL be registered-state decodes with no combinational path from the start inputs.
REQ-030 rd_a and rd_b SHALL never be high in the same cycle.

Reset
REQ-031 reset SHALL asynchronously force:
  - state IDLE;
  - word_ptr=0, latched mode=aequb, latched L=0;
  - memren, rd_a, rd_b, mul_en, sub_wen, red_done and busy all 0.
REQ-032 Reset asserted mid-operation SHALL drop every output to 0 immediately and SHALL NOT produce red_done.

Structure
REQ-033 State encoding (one-hot, 6 bits) and the 6-bit word-width constant SHALL live in the shared SPU package.
REQ-034 The word-pointer counter (clear, increment, compare-to-L) SHALL be a single sub-module, spu_mamrs_ctr.

Verification
REQ-035 aequb, L=3, m_ge_n=0:
  - rd_a and memren high in cycles 1-4, word_ptr 0,1,2,3;
  - CHK in cycle 5;
  - red_done high only in cycle 6.
REQ-036 anoteqb, L=3, m_ge_n=1:
  - RDA/RDB alternate in cycles 1-8;
  - CHK in cycle 9;
  - sub_wen high in cycles 10-13, word_ptr 0-3;
  - red_done in cycle 14.
REQ-037 anoteqb, L=0, m_ge_n=0 -> rd_a in cycle 1, rd_b in cycle 2, CHK in cycle 3, red_done in cycle 4.
REQ-038 kill_op in cycle 3 of anoteqb L=5 -> IDLE in cycle 4, busy=0, no red_done; a new aequb start in cycle 6 completes normally.
REQ-039 Both starts in the same cycle, L=1 -> aequb flow (no rd_b), red_done in cycle 4. A start during SUB -> ignored.
REQ-040 Async reset asserted mid-RDB -> all outputs 0 with no clock edge; after release the block is in IDLE with word_ptr=0.
